// File: rtl/uart_reg_responder.sv
// Register-access responder on the user side of a UART PHY byte interface.
// Decodes read/write command bytes against an 8-bit register bank and returns one response byte per command.
module uart_reg_responder #(
    parameter int         NUM_REGS       = 16,
    parameter int         TIMEOUT_CYCLES = 110000,
    parameter logic [7:0] ACK_BYTE       = 8'hA5,
    parameter logic [7:0] NAK_BYTE       = 8'hEE
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [7:0]            byte_rx,
    input  logic                  new_byte_rx,
    input  logic                  done_tx,
    output logic [7:0]            byte_tx,
    output logic                  start_tx,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  wr_pulse,
    output logic [3:0]            wr_addr,
    output logic [7:0]            overrun_cnt
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       NUM_REGS_W = 5'(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_regs [NUM_REGS];
    logic [3:0]       r_addr;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_byte_tx;
    logic             r_start_tx;
    logic             r_wr_pulse;
    logic [3:0]       r_wr_addr;
    logic [7:0]       r_overrun;

    logic [7:0]       w_rd_data;
    logic             w_wr_in_range;
    logic             w_overrun;

    // Read data defaults to NAK so out-of-range addresses need no separate check.
    always_comb begin
        w_rd_data = NAK_BYTE;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (byte_rx[3:0] == 4'(k)) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    assign w_wr_in_range = ({1'b0, r_addr} < NUM_REGS_W);
    assign w_overrun     = new_byte_rx &&
                           ((r_state == SEND) || (r_state == WAIT_BUSY) || (r_state == WAIT_DONE));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_byte_tx  <= '0;
            r_start_tx <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_start_tx <= 1'b0;
            r_wr_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (new_byte_rx) begin
                        if (byte_rx[7]) begin
                            r_addr  <= byte_rx[3:0];
                            r_cnt   <= '0;
                            r_state <= WAIT_DATA;
                        end else begin
                            r_byte_tx <= w_rd_data;
                            r_state   <= SEND;
                        end
                    end
                end
                // A data byte on the timeout edge still wins over the timeout.
                WAIT_DATA: begin
                    if (new_byte_rx) begin
                        if (w_wr_in_range) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (r_addr == 4'(k)) begin
                                    r_regs[k] <= byte_rx;
                                end
                            end
                            r_wr_pulse <= 1'b1;
                            r_wr_addr  <= r_addr;
                            r_byte_tx  <= ACK_BYTE;
                        end else begin
                            r_byte_tx <= NAK_BYTE;
                        end
                        r_state <= SEND;
                    end else if (r_cnt >= CNT_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (done_tx) begin
                        r_start_tx <= 1'b1;
                        r_state    <= WAIT_BUSY;
                    end
                end
                // done_tx is still high from before the request; wait for the PHY to go busy first.
                WAIT_BUSY: begin
                    if (!done_tx) begin
                        r_state <= WAIT_BUSY == r_state ? WAIT_DONE : r_state;
                    end
                end
                WAIT_DONE: begin
                    if (done_tx) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_overrun <= '0;
        end else if (w_overrun && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[8*g +: 8] = r_regs[g];
    end

    assign byte_tx     = r_byte_tx;
    assign start_tx    = r_start_tx;
    assign wr_pulse    = r_wr_pulse;
    assign wr_addr     = r_wr_addr;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: a behavioural register model predicts responses and writes,
// while a combined PHY model and monitor checks whatever the DUT transmits or writes.
module tb_uart_reg_responder;

    localparam int         NUM_REGS = 8;
    localparam int         TIMEOUT  = 50;
    localparam logic [7:0] ACK      = 8'hA5;
    localparam logic [7:0] NAK      = 8'hEE;

    logic                  clk;
    logic                  arst;
    logic [7:0]            byte_rx;
    logic                  new_byte_rx;
    logic                  done_tx;
    logic [7:0]            byte_tx;
    logic                  start_tx;
    logic [8*NUM_REGS-1:0] regs_out;
    logic                  wr_pulse;
    logic [3:0]            wr_addr;
    logic [7:0]            overrun_cnt;

    int         checks = 0;
    int         failures = 0;
    int         cycleCount = 0;
    logic [7:0] expRespQ[$];
    logic [3:0] expWrAddrQ[$];
    logic [7:0] expWrDataQ[$];
    logic [7:0] model[16];
    int         modelOverrun;
    int         startCount = 0;
    int         lastStartCycle = -1;
    int         lastWrCycle = -1;
    int         lastCmdEdge;
    int         lastDataEdge;
    logic       prevStart = 1'b0;
    logic       holdBusy = 1'b0;
    logic       phyBusy = 1'b0;
    int         phyState = 0;
    int         phyCnt = 0;
    int         dropDelay = 2;
    int         frameLen = 10;
    logic [7:0] phyByte;

    assign done_tx = !(holdBusy || phyBusy);

    uart_reg_responder #(
        .NUM_REGS      (NUM_REGS),
        .TIMEOUT_CYCLES(TIMEOUT),
        .ACK_BYTE      (ACK),
        .NAK_BYTE      (NAK)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .byte_rx    (byte_rx),
        .new_byte_rx(new_byte_rx),
        .done_tx    (done_tx),
        .byte_tx    (byte_tx),
        .start_tx   (start_tx),
        .regs_out   (regs_out),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s (cycle %0d)", name, cycleCount);
    endtask

    // PHY model and monitor share one process so queue pops and PHY state change atomically.
    initial begin
        logic [3:0] a;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (start_tx) begin
                startCount++;
                lastStartCycle = cycleCount;
                checkOutput("start_tx one-cycle", 64'(prevStart), 64'(0));
                if (expRespQ.size() == 0) begin
                    reportFail($sformatf("unexpected start_tx with byte_tx=%02h, expected none", byte_tx));
                end else begin
                    checkOutput("response byte", 64'(byte_tx), 64'(expRespQ.pop_front()));
                end
            end
            prevStart = start_tx;
            if (wr_pulse) begin
                lastWrCycle = cycleCount;
                if (expWrAddrQ.size() == 0) begin
                    reportFail($sformatf("unexpected wr_pulse at wr_addr=%0d, expected none", wr_addr));
                end else begin
                    a = expWrAddrQ.pop_front();
                    d = expWrDataQ.pop_front();
                    checkOutput("wr_addr", 64'(wr_addr), 64'(a));
                    checkOutput("written register", 64'(regs_out[8*a +: 8]), 64'(d));
                end
            end
            if (arst) begin
                phyState = 0;
                phyBusy  = 1'b0;
            end else begin
                case (phyState)
                    0: if (start_tx) begin
                        phyByte  = byte_tx;
                        phyCnt   = dropDelay;
                        phyState = 1;
                    end
                    1: begin
                        phyCnt--;
                        if (phyCnt == 0) begin
                            phyBusy  = 1'b1;
                            phyCnt   = frameLen;
                            phyState = 2;
                        end
                    end
                    default: begin
                        phyCnt--;
                        if (phyCnt == 0) begin
                            checkOutput("byte_tx held through frame", 64'(byte_tx), 64'(phyByte));
                            phyBusy  = 1'b0;
                            phyState = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] b, output int edgeIdx);
        byte_rx     = b;
        new_byte_rx = 1'b1;
        edgeIdx     = cycleCount + 1;
        @(negedge clk);
        new_byte_rx = 1'b0;
    endtask

    function automatic logic [7:0] expectRead(input logic [3:0] a);
        if (int'(a) < NUM_REGS) return model[a];
        return NAK;
    endfunction

    task automatic doRead(input logic [7:0] cmd);
        int e;
        expRespQ.push_back(expectRead(cmd[3:0]));
        applyStimulus(cmd, e);
        lastCmdEdge = e;
    endtask

    task automatic doWrite(input logic [7:0] cmd, input logic [7:0] data, input int gap);
        int e;
        applyStimulus(cmd, e);
        lastCmdEdge = e;
        repeat (gap - 1) @(negedge clk);
        if (gap <= TIMEOUT) begin
            if (int'(cmd[3:0]) < NUM_REGS) begin
                model[cmd[3:0]] = data;
                expWrAddrQ.push_back(cmd[3:0]);
                expWrDataQ.push_back(data);
                expRespQ.push_back(ACK);
            end else begin
                expRespQ.push_back(NAK);
            end
        end else if (!data[7]) begin
            // The write timed out, so this byte is decoded as a fresh read command.
            expRespQ.push_back(expectRead(data[3:0]));
        end
        applyStimulus(data, e);
        lastDataEdge = e;
    endtask

    task automatic discardBytes(input int n);
        int e;
        for (int i = 0; i < n; i++) begin
            applyStimulus(8'($urandom), e);
            if (modelOverrun < 255) modelOverrun++;
        end
    endtask

    task automatic waitStart(input int snap);
        int n = 0;
        while (startCount == snap && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) reportFail("start_tx never arrived");
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((expRespQ.size() != 0 || phyState != 0 || !done_tx) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            reportFail("response wait budget expired");
            expRespQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkState(input string tag);
        logic [8*NUM_REGS-1:0] flat;
        for (int k = 0; k < NUM_REGS; k++) flat[8*k +: 8] = model[k];
        checkOutput({tag, " regs_out"}, 64'(regs_out), 64'(flat));
        checkOutput({tag, " overrun_cnt"}, 64'(overrun_cnt), 64'(modelOverrun));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " start_tx"}, 64'(start_tx), 64'(0));
        checkOutput({tag, " byte_tx"}, 64'(byte_tx), 64'(0));
        checkOutput({tag, " regs_out"}, 64'(regs_out), 64'(0));
        checkOutput({tag, " wr_pulse"}, 64'(wr_pulse), 64'(0));
        checkOutput({tag, " wr_addr"}, 64'(wr_addr), 64'(0));
        checkOutput({tag, " overrun_cnt"}, 64'(overrun_cnt), 64'(0));
    endtask

    initial begin
        int e;
        int snap;
        int rel;
        arst        = 1'b1;
        new_byte_rx = 1'b0;
        byte_rx     = 8'h00;
        modelOverrun = 0;
        for (int k = 0; k < 16; k++) model[k] = 8'h00;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);

        $display("[TB] write/read reg3");
        doWrite(8'h83, 8'h5C, 1);
        waitIdle();
        checkOutput("wr_pulse cycle", 64'(lastWrCycle), 64'(lastDataEdge));
        checkOutput("write start_tx latency", 64'(lastStartCycle), 64'(lastDataEdge + 1));
        checkState("after write");
        doRead(8'h03);
        waitIdle();
        checkOutput("read start_tx latency", 64'(lastStartCycle), 64'(lastCmdEdge + 1));

        $display("[TB] out-of-range accesses");
        doRead(8'h0A);
        waitIdle();
        doWrite(8'h8A, 8'h11, 3);
        waitIdle();
        checkState("after NAK write");

        $display("[TB] write timeout");
        snap = startCount;
        applyStimulus(8'h81, e);
        repeat (TIMEOUT + 10) @(negedge clk);
        checkOutput("no start_tx after timeout", 64'(startCount), 64'(snap));
        doRead(8'h01);
        waitIdle();
        doWrite(8'h84, 8'h3C, TIMEOUT);
        waitIdle();
        doWrite(8'h85, 8'h06, TIMEOUT + 1);
        waitIdle();
        checkState("after timeout boundary");

        $display("[TB] overrun during transmission");
        frameLen = 20;
        snap = startCount;
        doRead(8'h02);
        waitStart(snap);
        discardBytes(1);
        repeat (3) @(negedge clk);
        discardBytes(2);
        waitIdle();
        checkOutput("single response with overrun", 64'(startCount), 64'(snap + 1));
        checkState("after overrun");

        $display("[TB] deferred start");
        holdBusy = 1'b1;
        snap = startCount;
        doRead(8'h03);
        repeat (20) @(negedge clk);
        checkOutput("start_tx held while busy", 64'(startCount), 64'(snap));
        holdBusy = 1'b0;
        rel = cycleCount;
        waitIdle();
        checkOutput("deferred start_tx cycle", 64'(lastStartCycle), 64'(rel + 1));

        $display("[TB] delayed busy");
        dropDelay = 5;
        frameLen  = 8;
        snap = startCount;
        doRead(8'h04);
        waitStart(snap);
        discardBytes(1);
        waitIdle();
        checkOutput("single response with late busy", 64'(startCount), 64'(snap + 1));
        checkState("after late busy");

        $display("[TB] randomized traffic");
        for (int it = 0; it < 40; it++) begin
            logic [7:0] cmd;
            logic [7:0] data;
            int kind;
            int extra;
            dropDelay = $urandom_range(1, 4);
            frameLen  = $urandom_range(2, 12);
            cmd  = 8'($urandom);
            data = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                cmd[7] = 1'b1;
                snap = startCount;
                applyStimulus(cmd, e);
                repeat (TIMEOUT + 5) @(negedge clk);
                checkOutput("random timeout no start_tx", 64'(startCount), 64'(snap));
            end else begin
                extra = (kind == 1) ? $urandom_range(1, 3) : 0;
                if (extra != 0) holdBusy = 1'b1;
                if (cmd[7]) doWrite(cmd, data, $urandom_range(1, TIMEOUT));
                else doRead(cmd);
                if (extra != 0) begin
                    discardBytes(extra);
                    holdBusy = 1'b0;
                end
                waitIdle();
                checkState("random");
            end
        end

        $display("[TB] overrun flood");
        dropDelay = 2;
        frameLen  = 10;
        holdBusy  = 1'b1;
        doRead(8'h03);
        discardBytes(300);
        holdBusy = 1'b0;
        waitIdle();
        checkState("after flood");

        $display("[TB] reset during WAIT_DONE");
        frameLen = 30;
        snap = startCount;
        doWrite(8'h81, 8'h77, 2);
        waitStart(snap);
        repeat (6) @(negedge clk);
        #2 arst = 1'b1;
        #1 checkResetOutputs("mid-frame reset");
        for (int k = 0; k < 16; k++) model[k] = 8'h00;
        modelOverrun = 0;
        expRespQ.delete();
        expWrAddrQ.delete();
        expWrDataQ.delete();
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        doRead(8'h01);
        waitIdle();
        checkState("after reset");

        checkOutput("pending responses", 64'(expRespQ.size()), 64'(0));
        checkOutput("pending writes", 64'(expWrAddrQ.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
